aes_decryption_iter: RTL and testbench

- Iterative AES-256 decryptor. It is the inverse-direction companion of the combinational aes_encryption core.
- Accepts one 128-bit ciphertext and a 256-bit key through a valid/ready handshake.
- Expands the key schedule in-block, then runs one inverse round per cycle.
- Presents the plaintext through a valid/yumi handshake for the chip's AES datapath.

---
 rtl/aes_pkg.sv | 100 ++++++++++
 rtl/aes_inv_round.sv | 26 ++
 rtl/aes_decryption_iter.sv | 161 ++++++++++++++++
 tb/tb_aes_decryption_iter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES constants, types and GF(2^8) helpers for the AES-256 datapath.
// Contents: forward/inverse S-boxes, Rcon, byte-wise round transforms
// (inv_shift_rows, inv_sub_bytes, inv_mix_columns) and key-schedule helpers
// (sub_word, rot_word). State byte 0 lives in bits [127:120]; byte 4c+r is
// row r of column c.
// -----------------------------------------------------------------------------
package aes_pkg;

   localparam int NR = 14;
   localparam int NK = 8;

   typedef logic [127:0] aes_state_t;
   typedef logic [31:0]  aes_word_t;

   typedef enum logic [2:0] {IDLE, EXPAND, ADDKEY, ROUND, DONE} aes_fsm_t;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   // Indexed by i/8 of the key word being generated; entry 0 is never used.
   localparam logic [0:7][7:0] RCON = {8'h00, 8'h01, 8'h02, 8'h04,
                                       8'h08, 8'h10, 8'h20, 8'h40};

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a small constant (9, b, d, e) through repeated doubling.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
      logic [7:0] a2, a4, a8;
      a2 = xtime(a);
      a4 = xtime(a2);
      a8 = xtime(a4);
      return (c[0] ? a : 8'h00) ^ (c[1] ? a2 : 8'h00) ^
             (c[2] ? a4 : 8'h00) ^ (c[3] ? a8 : 8'h00);
   endfunction

   // Row r is rotated right by r columns.
   function automatic aes_state_t inv_shift_rows(input aes_state_t s);
      aes_state_t o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      return o;
   endfunction

   function automatic aes_state_t inv_sub_bytes(input aes_state_t s);
      aes_state_t o;
      o = '0;
      for (int i = 0; i < 16; i++)
         o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
      return o;
   endfunction

   function automatic aes_state_t inv_mix_columns(input aes_state_t s);
      aes_state_t o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0,4'he) ^ gmul(a1,4'hb) ^ gmul(a2,4'hd) ^ gmul(a3,4'h9);
         o[119-32*c -: 8] = gmul(a0,4'h9) ^ gmul(a1,4'he) ^ gmul(a2,4'hb) ^ gmul(a3,4'hd);
         o[111-32*c -: 8] = gmul(a0,4'hd) ^ gmul(a1,4'h9) ^ gmul(a2,4'he) ^ gmul(a3,4'hb);
         o[103-32*c -: 8] = gmul(a0,4'hb) ^ gmul(a1,4'hd) ^ gmul(a2,4'h9) ^ gmul(a3,4'he);
      end
      return o;
   endfunction

   function automatic aes_word_t sub_word(input aes_word_t w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic aes_word_t rot_word(input aes_word_t w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// -----------------------------------------------------------------------------
// aes_inv_round
// One combinational AES inverse round:
//   next = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key),
// with InvMixColumns bypassed on the final round.
// Ports:
//   state       in  128  current cipher state
//   round_key   in  128  round key for this round
//   final_round in  1    skip InvMixColumns
//   next_state  out 128  resulting state
// -----------------------------------------------------------------------------
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] round_key,
   input  logic         final_round,
   output logic [127:0] next_state
);

   aes_state_t keyed;

   assign keyed      = inv_sub_bytes(inv_shift_rows(state)) ^ round_key;
   assign next_state = final_round ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_decryption_iter.sv
// -----------------------------------------------------------------------------
// aes_decryption_iter
// Iterative AES-256 decryptor. Accepts ciphertext + key on a valid/ready
// handshake, expands the key schedule 4 words per cycle, applies rk14, then
// runs one inverse round per cycle and presents the plaintext on valid/yumi.
// Ports:
//   clk_i          in  1    clock, rising edge
//   reset_n_i      in  1    synchronous active-low reset
//   v_i            in  1    ciphertext/key valid
//   ready_o        out 1    accepting input (IDLE only)
//   ciphertext_i   in  128  ciphertext, byte 0 in [127:120]
//   initial_key_i  in  256  cipher key, MSB-first byte order
//   v_o            out 1    plaintext valid, held until yumi_i
//   plaintext_o    out 128  decrypted block
//   yumi_i         in  1    consumer takes plaintext_o
// Optional build macro AES_KEY_CACHE_EN: reuse the previous key schedule when
// the incoming key matches the last expanded key, skipping EXPAND.
// -----------------------------------------------------------------------------
module aes_decryption_iter
   import aes_pkg::*;
(
   input  logic         clk_i,
   input  logic         reset_n_i,
   input  logic         v_i,
   output logic         ready_o,
   input  logic [127:0] ciphertext_i,
   input  logic [255:0] initial_key_i,
   output logic         v_o,
   output logic [127:0] plaintext_o,
   input  logic         yumi_i
);

   aes_fsm_t   st;
   aes_state_t state_r;
   aes_word_t  w [0:59];
   logic [3:0] kidx;        // expansion step, 0..12
   logic [3:0] rnd;         // inverse round index, 13..0
   logic [5:0] base;        // first key word produced this expansion step
   logic [5:0] widx;
   aes_word_t  nw0, nw1, nw2, nw3;
   aes_state_t rk;
   aes_state_t rk14;
   aes_state_t round_out;
   logic       cache_hit;

`ifdef AES_KEY_CACHE_EN
   logic [255:0] cached_key;
   logic         cache_vld;
   assign cache_hit = cache_vld && (initial_key_i == cached_key);
`else
   assign cache_hit = 1'b0;
`endif

   // Key expansion: steps with even kidx start on an i%8==0 word, odd on i%8==4.
   always_comb begin
      base = 6'(NK) + {kidx, 2'b00};
      if (!kidx[0])
         nw0 = sub_word(rot_word(w[base-6'd1])) ^ {RCON[base[5:3]], 24'h0} ^ w[base-6'd8];
      else
         nw0 = sub_word(w[base-6'd1]) ^ w[base-6'd8];
      nw1 = nw0 ^ w[base-6'd7];
      nw2 = nw1 ^ w[base-6'd6];
      nw3 = nw2 ^ w[base-6'd5];
   end

   assign widx = {rnd, 2'b00};
   assign rk   = {w[widx], w[widx+6'd1], w[widx+6'd2], w[widx+6'd3]};
   assign rk14 = {w[56], w[57], w[58], w[59]};

   aes_inv_round u_round (
      .state       (state_r),
      .round_key   (rk),
      .final_round (rnd == 4'd0),
      .next_state  (round_out)
   );

   // Control FSM and registered handshake outputs.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         st          <= IDLE;
         ready_o     <= 1'b1;
         v_o         <= 1'b0;
         plaintext_o <= '0;
         rnd         <= '0;
         kidx        <= '0;
`ifdef AES_KEY_CACHE_EN
         cache_vld   <= 1'b0;
`endif
      end else begin
         case (st)
            IDLE: if (v_i) begin
               ready_o <= 1'b0;
               kidx    <= '0;
               if (cache_hit) begin
                  st <= ADDKEY;
               end else begin
                  st <= EXPAND;
`ifdef AES_KEY_CACHE_EN
                  // Schedule is being overwritten; it is only trustworthy once EXPAND ends.
                  cache_vld <= 1'b0;
`endif
               end
            end
            EXPAND: begin
               kidx <= kidx + 4'd1;
               if (kidx == 4'd12) begin
                  st <= ADDKEY;
`ifdef AES_KEY_CACHE_EN
                  cache_vld <= 1'b1;
`endif
               end
            end
            ADDKEY: begin
               rnd <= 4'(NR - 1);
               st  <= ROUND;
            end
            ROUND: begin
               if (rnd == 4'd0) begin
                  plaintext_o <= round_out;
                  v_o         <= 1'b1;
                  st          <= DONE;
               end else begin
                  rnd <= rnd - 4'd1;
               end
            end
            DONE: if (yumi_i) begin
               v_o     <= 1'b0;
               ready_o <= 1'b1;
               st      <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end

   // Datapath: cipher state and key schedule, no reset needed.
   always_ff @(posedge clk_i) begin
      case (st)
         IDLE: if (v_i) begin
            state_r <= ciphertext_i;
            if (!cache_hit) begin
               for (int j = 0; j < 8; j++)
                  w[j] <= initial_key_i[255-32*j -: 32];
`ifdef AES_KEY_CACHE_EN
               cached_key <= initial_key_i;
`endif
            end
         end
         EXPAND: begin
            w[base]       <= nw0;
            w[base+6'd1]  <= nw1;
            w[base+6'd2]  <= nw2;
            w[base+6'd3]  <= nw3;
         end
         ADDKEY: state_r <= state_r ^ rk14;
         ROUND:  state_r <= round_out;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_aes_decryption_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_decryption_iter
// Directed bench for aes_decryption_iter using published AES-256 vectors:
// latency, backpressure, busy-input rejection, mid-job reset and (with
// AES_KEY_CACHE_EN) the shortened cached-key latency.
// -----------------------------------------------------------------------------
module tb_aes_decryption_iter;

   localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PT_C3  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] KEY_SP = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] CT_SP  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
   localparam logic [127:0] PT_SP  = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam int LAT_FULL = 29;
`ifdef AES_KEY_CACHE_EN
   localparam int LAT_REUSE = 16;
`else
   localparam int LAT_REUSE = 29;
`endif

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         v_i = 1'b0;
   logic         ready;
   logic [127:0] ct_in = '0;
   logic [255:0] key_in = '0;
   logic         v_o;
   logic [127:0] pt;
   logic         yumi = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   int lat;

   always #5 clk = ~clk;

   aes_decryption_iter dut (
      .clk_i         (clk),
      .reset_n_i     (reset_n),
      .v_i           (v_i),
      .ready_o       (ready),
      .ciphertext_i  (ct_in),
      .initial_key_i (key_in),
      .v_o           (v_o),
      .plaintext_o   (pt),
      .yumi_i        (yumi)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present one job; returns #1 after the accepting edge.
   task automatic start_job(input logic [255:0] key, input logic [127:0] ct);
      @(negedge clk);
      chk("ready_before_accept", 128'(ready), 128'd1);
      v_i    = 1'b1;
      key_in = key;
      ct_in  = ct;
      @(posedge clk); #1;
      v_i    = 1'b0;
      ct_in  = '0;
   endtask

   // Count edges until v_o, starting from an edge count already elapsed.
   task automatic wait_out(input int start, output int n);
      n = start;
      while (!v_o && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("v_o_seen", 128'(v_o), 128'd1);
   endtask

   task automatic consume(input logic [127:0] exp_pt);
      @(negedge clk);
      yumi = 1'b1;
      @(posedge clk); #1;
      yumi = 1'b0;
      chk("ready_after_yumi", 128'(ready), 128'd1);
      chk("v_o_after_yumi", 128'(v_o), 128'd0);
      chk("pt_kept_after_yumi", pt, exp_pt);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", 128'(ready), 128'd1);
      chk("reset_v_o", 128'(v_o), 128'd0);
      chk("reset_pt", pt, 128'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Job 1: FIPS-197 C.3 with 10 cycles of backpressure
      start_job(KEY_C3, CT_C3);
      chk("c3_no_early_v_o", 128'(v_o), 128'd0);
      wait_out(1, lat);
      chk("c3_latency", 128'(lat), 128'(LAT_FULL));
      chk("c3_pt", pt, PT_C3);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         chk("bp_v_o", 128'(v_o), 128'd1);
         chk("bp_pt", pt, PT_C3);
         chk("bp_ready", 128'(ready), 128'd0);
      end
      consume(PT_C3);

      // Job 2: SP800-38A with an ignored job and stray yumi at A+5
      start_job(KEY_SP, CT_SP);
      repeat (4) begin @(posedge clk); #1; end
      chk("busy_ready", 128'(ready), 128'd0);
      v_i    = 1'b1;
      key_in = KEY_C3;
      ct_in  = CT_C3;
      yumi   = 1'b1;
      @(posedge clk); #1;
      v_i    = 1'b0;
      yumi   = 1'b0;
      key_in = KEY_SP;
      chk("busy_no_v_o", 128'(v_o), 128'd0);
      wait_out(6, lat);
      chk("sp_latency", 128'(lat), 128'(LAT_FULL));
      chk("sp_pt", pt, PT_SP);
      consume(PT_SP);

      // Job 3: reset during cycle A+20
      start_job(KEY_C3, CT_C3);
      repeat (19) begin @(posedge clk); #1; end
      chk("midop_v_o_before", 128'(v_o), 128'd0);
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      chk("midop_ready", 128'(ready), 128'd1);
      chk("midop_v_o", 128'(v_o), 128'd0);
      chk("midop_pt", pt, 128'd0);
      @(posedge clk); #1;
      chk("midop_still_idle", 128'(ready), 128'd1);

      // Job 4: fresh C.3 after reset
      start_job(KEY_C3, CT_C3);
      wait_out(1, lat);
      chk("fresh_latency", 128'(lat), 128'(LAT_FULL));
      chk("fresh_pt", pt, PT_C3);
      consume(PT_C3);

      // Job 5: same key again
      start_job(KEY_C3, CT_C3);
      wait_out(1, lat);
      chk("reuse_latency", 128'(lat), 128'(LAT_REUSE));
      chk("reuse_pt", pt, PT_C3);
      consume(PT_C3);

      // Job 6: different key forces full expansion
      start_job(KEY_SP, CT_SP);
      wait_out(1, lat);
      chk("newkey_latency", 128'(lat), 128'(LAT_FULL));
      chk("newkey_pt", pt, PT_SP);
      consume(PT_SP);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
